// File: rtl/fifo_burst_writer_pkg.sv
// Shared types and constants for the FIFO burst writer.
// The LFSR tap masks are used only when BURST_WR_LFSR_EN is defined.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bw_state_t;

  localparam int unsigned STALL_W = 16;

  // Maximal-length Fibonacci feedback masks (bit i set = tap on word[i]).
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;         // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;      // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003; // x^32+x^22+x^2+x^1+1

  // Returns the tap mask for a given width. For an unlisted width it
  // falls back to the two top bits, which still gives a non-stuck sequence.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       lfsr_taps = {24'h0, LFSR_TAPS_8};
      16:      lfsr_taps = {16'h0, LFSR_TAPS_16};
      32:      lfsr_taps = LFSR_TAPS_32;
      default: lfsr_taps = 32'h3 << (width - 2);
    endcase
  endfunction

endpackage

// File: rtl/fifo_burst_writer_pattern_gen.sv
// Data pattern source for the burst writer.
// Default build: incrementing word starting at seed.
// BURST_WR_LFSR_EN defined: Fibonacci LFSR seeded by seed (seed 0 -> all-ones).
import fifo_burst_pkg::*;

module fifo_pattern_gen #(
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DSIZE-1:0] seed,
  input  logic             adv,
  output logic [DSIZE-1:0] word
);

  logic [DSIZE-1:0] load_word;
  logic [DSIZE-1:0] next_word;

`ifdef BURST_WR_LFSR_EN
  localparam logic [31:0]      TAPS_FULL = lfsr_taps(DSIZE);
  localparam logic [DSIZE-1:0] TAPS      = TAPS_FULL[DSIZE-1:0];

  // LFSR: zero seed would lock up, so substitute all-ones; shift left with XOR feedback.
  always_comb begin
    load_word = (seed == '0) ? '1 : seed;
    next_word = {word[DSIZE-2:0], ^(word & TAPS)};
  end
`else
  // Incrementing pattern, wraps naturally at 2^DSIZE.
  always_comb begin
    load_word = seed;
    next_word = word + DSIZE'(1);
  end
`endif

  // Holds the word currently presented on the FIFO write data bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (load) begin
      word <= load_word;
    end else if (adv) begin
      word <= next_word;
    end
  end

endmodule

// File: rtl/fifo_burst_writer.sv
// Burst producer for the async FIFO write port (wclk domain).
// A start pulse in IDLE pushes burst_len pattern words; writes stall
// while wfull is high and done pulses once when the burst ends or aborts.
// Optional feature macro: BURST_WR_LFSR_EN (LFSR data pattern instead of increment).
import fifo_burst_pkg::*;

module fifo_burst_writer #(
  parameter  int unsigned DSIZE     = 8,
  parameter  int unsigned MAX_BURST = 512,
  localparam int unsigned LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   burst_len,
  input  logic [DSIZE-1:0]   seed,
  input  logic               wfull,
  output logic               winc,
  output logic [DSIZE-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [STALL_W-1:0] stall_cnt
);

  bw_state_t        state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_clamped;
  logic             load;
  logic             last_word;

  // Requested length limited to MAX_BURST; start is only honoured in IDLE.
  always_comb begin
    len_clamped = (burst_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : burst_len;
    load        = (state == IDLE) && start;
    last_word   = (count == len_q - LEN_W'(1));
  end

  // Write enable reacts to wfull in the same cycle so no word is lost or repeated.
  assign winc = (state == RUN) && !wfull;

  fifo_pattern_gen #(
    .DSIZE (DSIZE)
  ) u_pattern_gen (
    .clk   (wclk),
    .rst_n (wrst_n),
    .load  (load),
    .seed  (seed),
    .adv   (winc),
    .word  (wdata)
  );

  // Burst FSM with word count, stall counter and registered busy/done.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      count     <= '0;
      stall_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len_clamped;
            count     <= '0;
            stall_cnt <= '0;
            if (len_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (winc) begin
            count <= count + LEN_W'(1);
          end
          if (wfull && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
          // An abort coinciding with a write still lets that word count as written.
          if (abort || (winc && last_word)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Self-checking bench for fifo_burst_writer: directed bursts plus randomized
// bursts with random FIFO back-pressure and aborts, checked every cycle
// against a transaction-level model of the burst behaviour.
module tb_fifo_burst_writer;

  localparam int LEN_W = 10;

  logic             wclk = 1'b0;
  logic             wrst_n;
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] burst_len;
  logic [7:0]       seed;
  logic             wfull;
  logic             winc;
  logic [7:0]       wdata;
  logic             busy;
  logic             done;
  logic [15:0]      stall_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0] got[$];
  int         done_cnt;

  // Model state: burst bookkeeping in plain integers.
  bit         m_active;
  bit         m_done;
  bit         m_loaded;
  int         m_len;
  int         m_written;
  int         m_stall;
  logic [7:0] m_seed;

  fifo_burst_writer #(
    .DSIZE     (8),
    .MAX_BURST (512)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .start     (start),
    .abort     (abort),
    .burst_len (burst_len),
    .seed      (seed),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // n-th word of a burst, computed directly from the pattern definition.
  function automatic logic [7:0] pat(input logic [7:0] s, input int n);
    logic [7:0] v;
`ifdef BURST_WR_LFSR_EN
    v = (s == 8'h00) ? 8'hFF : s;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
    v = s + 8'(n);
`endif
    return v;
  endfunction

  // Reference model, advanced at each clock edge from the sampled inputs.
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_active  <= 1'b0;
      m_done    <= 1'b0;
      m_loaded  <= 1'b0;
      m_len     <= 0;
      m_written <= 0;
      m_stall   <= 0;
      m_seed    <= 8'h00;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_active) begin
      if (!wfull) m_written <= m_written + 1;
      else if (m_stall < 65535) m_stall <= m_stall + 1;
      if (abort || (!wfull && (m_written + 1 == m_len))) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
    end else if (start) begin
      m_len     <= (int'(burst_len) > 512) ? 512 : int'(burst_len);
      m_seed    <= seed;
      m_written <= 0;
      m_stall   <= 0;
      m_loaded  <= 1'b1;
      if (burst_len == '0) m_done <= 1'b1;
      else m_active <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, plus capture of written words.
  always @(negedge wclk) begin
    if (wrst_n) begin
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("winc", winc, m_active && !wfull);
      chk("wdata", wdata, m_loaded ? pat(m_seed, m_written) : 8'h00);
      chk("stall_cnt", stall_cnt, m_stall);
      if (winc) got.push_back(wdata);
      if (done) done_cnt++;
    end
  end

  // mode 0: never full; 1: random full; 2: full for 3 cycles after 2 words.
  task automatic do_burst(input int len, input logic [7:0] sd, input int mode,
                          input int abort_after, output int words, output int dones);
    int  stall_left;
    bit  fired;
    bit  seen;
    @(posedge wclk); #1;
    got.delete();
    done_cnt  = 0;
    start     = 1'b1;
    burst_len = LEN_W'(len);
    seed      = sd;
    @(posedge wclk); #1;
    start      = 1'b0;
    stall_left = 3;
    fired      = 1'b0;
    seen       = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (mode)
        1: wfull = ($urandom_range(0, 3) == 0);
        2: begin
          if (got.size() >= 2 && stall_left > 0) begin
            wfull = 1'b1;
            stall_left--;
          end else begin
            wfull = 1'b0;
          end
        end
        default: wfull = 1'b0;
      endcase
      if (abort_after >= 0 && !fired && got.size() >= abort_after) begin
        abort = 1'b1;
        fired = 1'b1;
      end else begin
        abort = 1'b0;
      end
      @(posedge wclk); #1;
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
    abort = 1'b0;
    wfull = 1'b0;
    @(posedge wclk); #1;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within budget, len=%0d", len);
    end
    words = got.size();
    dones = done_cnt;
  endtask

  initial begin
    int words, dones, len, ab;
    wrst_n    = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    burst_len = '0;
    seed      = 8'h00;
    wfull     = 1'b0;
    done_cnt  = 0;
    repeat (3) @(posedge wclk);
    #1;
    chk("rst_winc", winc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_stall", stall_cnt, 16'h0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Plain 4-word burst.
    do_burst(4, 8'h10, 0, -1, words, dones);
    chk("t1_words", words, 4);
    chk("t1_dones", dones, 1);
    chk("t1_stall", stall_cnt, 16'd0);
`ifndef BURST_WR_LFSR_EN
    chk("t1_w0", got[0], 8'h10);
    chk("t1_w3", got[3], 8'h13);
`endif

    // Wrap-around with a 3-cycle stall after word 2.
    do_burst(6, 8'hFE, 2, -1, words, dones);
    chk("t2_words", words, 6);
    chk("t2_stall", stall_cnt, 16'd3);
`ifndef BURST_WR_LFSR_EN
    chk("t2_w1", got[1], 8'hFF);
    chk("t2_w2", got[2], 8'h00);
    chk("t2_w5", got[5], 8'h03);
`endif

    // Zero-length burst: done only.
    do_burst(0, 8'h22, 0, -1, words, dones);
    chk("t3_words", words, 0);
    chk("t3_dones", dones, 1);

    // Start held during DONE must not restart.
    got.delete();
    done_cnt = 0;
    @(posedge wclk); #1;
    start = 1'b1; burst_len = 10'd1; seed = 8'h70;
    @(posedge wclk); #1;
    start = 1'b0;
    @(posedge wclk); #1;
    start = 1'b1;
    @(posedge wclk); #1;
    start = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    chk("t_done_start_words", got.size(), 1);
    chk("t_done_start_busy", busy, 1'b0);
    chk("t_done_start_dones", done_cnt, 1);

    // Abort after 5 words with no back-pressure: the 6th write coincides with abort.
    do_burst(20, 8'h55, 0, 5, words, dones);
    chk("t5_words", words, 6);
    chk("t5_dones", dones, 1);
    do_burst(3, 8'h80, 0, -1, words, dones);
    chk("t5_restart_words", words, 3);

    // Over-long request clamps to 512; then a full 512 burst under back-pressure.
    do_burst(700, 8'h01, 0, -1, words, dones);
    chk("clamp_words", words, 512);
    do_burst(512, 8'hA0, 1, -1, words, dones);
    chk("t4_words", words, 512);

    // Reset mid-burst clears outputs asynchronously.
    @(posedge wclk); #1;
    start = 1'b1; burst_len = 10'd20; seed = 8'h33;
    @(posedge wclk); #1;
    start = 1'b0; wfull = 1'b1;
    repeat (2) @(posedge wclk);
    #1;
    wfull = 1'b0;
    repeat (2) @(posedge wclk);
    #3;
    wrst_n = 1'b0;
    #1;
    chk("t6_winc", winc, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_wdata", wdata, 8'h00);
    chk("t6_stall", stall_cnt, 16'h0);
    @(negedge wclk);
    wrst_n = 1'b1;
    do_burst(3, 8'h40, 0, -1, words, dones);
    chk("t6_after_words", words, 3);
    chk("t6_after_dones", dones, 1);

`ifdef BURST_WR_LFSR_EN
    do_burst(3, 8'h00, 0, -1, words, dones);
    chk("lfsr_w0", got[0], 8'hFF);
    chk("lfsr_w1", got[1], 8'hFE);
`endif

    // Randomized bursts with back-pressure and occasional aborts.
    for (int i = 0; i < 25; i++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1;
      do_burst(len, 8'($urandom), 1, ab, words, dones);
      chk("rand_dones", dones, 1);
      repeat ($urandom_range(0, 3)) @(posedge wclk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
